// File: rtl/rpc2_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level tracking, almost flags,
// flush and sticky overflow/underflow flags. o_level counts RAM plus output stage.
module rpc2_ctrl_sync_fifo #(
   parameter int FIFO_ADDR_BITS  = 3,
   parameter int FIFO_DATA_WIDTH = 16,
   parameter int SPLIT_MEM       = 0,
   parameter int AFULL_LEVEL     = 6,
   parameter int AEMPTY_LEVEL    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_flush,
   input  logic                       i_wr_en,
   input  logic [FIFO_DATA_WIDTH-1:0] i_wr_data,
   output logic                       o_full,
   output logic                       o_afull,
   input  logic                       i_rd_en,
   output logic                       o_rd_valid,
   output logic [FIFO_DATA_WIDTH-1:0] o_rd_data,
   output logic                       o_empty,
   output logic                       o_aempty,
   output logic [FIFO_ADDR_BITS:0]    o_level,
   output logic                       o_ovf,
   output logic                       o_udf,
   input  logic                       i_err_clr
);

   localparam int DEPTH = 1 << FIFO_ADDR_BITS;
   localparam logic [FIFO_ADDR_BITS:0] L_DEPTH  = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
   localparam logic [FIFO_ADDR_BITS:0] L_AFULL  = AFULL_LEVEL[FIFO_ADDR_BITS:0];
   localparam logic [FIFO_ADDR_BITS:0] L_AEMPTY = AEMPTY_LEVEL[FIFO_ADDR_BITS:0];
   localparam logic [FIFO_ADDR_BITS:0] L_ONE    = {{FIFO_ADDR_BITS{1'b0}}, 1'b1};

   logic [FIFO_ADDR_BITS:0]    r_wp;
   logic [FIFO_ADDR_BITS:0]    r_rp;
   logic [FIFO_ADDR_BITS:0]    r_level;
   logic                       r_rd_valid;
   logic [FIFO_DATA_WIDTH-1:0] r_rd_data;
   logic                       r_full;
   logic                       r_afull;
   logic                       r_empty;
   logic                       r_aempty;
   logic                       r_ovf;
   logic                       r_udf;

   logic                       w_push_acc;
   logic                       w_pop_acc;
   logic                       w_ram_empty;
   logic                       w_rd_fire;
   logic                       w_mem_we;
   logic [FIFO_ADDR_BITS:0]    w_level_nxt;
   logic [FIFO_DATA_WIDTH-1:0] w_mem_rdata;
   logic [FIFO_ADDR_BITS-1:0]  w_wr_addr;
   logic [FIFO_ADDR_BITS-1:0]  w_rd_addr;

   // Push accepted when i_wr_en && !full; pop accepted when i_rd_en && o_rd_valid.
   assign w_push_acc  = i_wr_en && !r_full;
   assign w_pop_acc   = i_rd_en && r_rd_valid;
   assign w_ram_empty = (r_wp == r_rp);
   // RAM emptiness is taken at the start of the cycle, so a read never hits
   // the address being written in the same cycle.
   assign w_rd_fire   = (!r_rd_valid || w_pop_acc) && !w_ram_empty;
   assign w_mem_we    = w_push_acc && !i_flush && !reset;
   assign w_wr_addr   = r_wp[FIFO_ADDR_BITS-1:0];
   assign w_rd_addr   = r_rp[FIFO_ADDR_BITS-1:0];

   always_comb begin
      w_level_nxt = r_level;
      if (w_push_acc && !w_pop_acc)
         w_level_nxt = r_level + L_ONE;
      else if (w_pop_acc && !w_push_acc)
         w_level_nxt = r_level - L_ONE;
   end

   generate
      if (SPLIT_MEM == 0) begin : g_mem_single
         logic [FIFO_DATA_WIDTH-1:0] r_mem [DEPTH];
         always_ff @(posedge clk) begin
            if (w_mem_we)
               r_mem[w_wr_addr] <= i_wr_data;
         end
         assign w_mem_rdata = r_mem[w_rd_addr];
      end else begin : g_mem_split
         localparam int HALF = FIFO_DATA_WIDTH / 2;
         logic [HALF-1:0] r_mem_lo [DEPTH];
         logic [HALF-1:0] r_mem_hi [DEPTH];
         always_ff @(posedge clk) begin
            if (w_mem_we) begin
               r_mem_lo[w_wr_addr] <= i_wr_data[HALF-1:0];
               r_mem_hi[w_wr_addr] <= i_wr_data[FIFO_DATA_WIDTH-1:HALF];
            end
         end
         assign w_mem_rdata = {r_mem_hi[w_rd_addr], r_mem_lo[w_rd_addr]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_full     <= 1'b0;
         r_afull    <= (AFULL_LEVEL == 0);
         r_empty    <= 1'b1;
         r_aempty   <= 1'b1;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else if (i_flush) begin
         // Contents are dropped but the error history is kept.
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_full     <= 1'b0;
         r_afull    <= (AFULL_LEVEL == 0);
         r_empty    <= 1'b1;
         r_aempty   <= 1'b1;
      end else begin
         if (w_push_acc)
            r_wp <= r_wp + L_ONE;
         if (w_rd_fire) begin
            r_rp       <= r_rp + L_ONE;
            r_rd_data  <= w_mem_rdata;
            r_rd_valid <= 1'b1;
         end else if (w_pop_acc) begin
            r_rd_valid <= 1'b0;
         end
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == L_DEPTH);
         r_afull  <= (w_level_nxt >= L_AFULL);
         r_empty  <= (w_level_nxt == '0);
         r_aempty <= (w_level_nxt <= L_AEMPTY);
         r_ovf    <= (i_wr_en && r_full) || (r_ovf && !i_err_clr);
         r_udf    <= (i_rd_en && !r_rd_valid) || (r_udf && !i_err_clr);
      end
   end

   assign o_full     = r_full;
   assign o_afull    = r_afull;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_empty    = r_empty;
   assign o_aempty   = r_aempty;
   assign o_level    = r_level;
   assign o_ovf      = r_ovf;
   assign o_udf      = r_udf;

endmodule

// File: tb/tb_rpc2_ctrl_sync_fifo.sv
// Bench for rpc2_ctrl_sync_fifo: single-array and split-array instances share
// stimulus and are both checked against a queue-based model and fixed vectors.
module tb_rpc2_ctrl_sync_fifo;

   localparam int DEPTH = 8;
   localparam int AFULL = 6;
   localparam int AEMPTY = 2;

   logic clk;
   logic reset, i_flush, i_wr_en, i_rd_en, i_err_clr;
   logic [15:0] i_wr_data;

   logic [1:0]       full, afull, rd_valid, empty, aempty, ovf, udf;
   logic [1:0][15:0] rd_data;
   logic [1:0][3:0]  level;

   int total = 0;
   int bad = 0;

   // model state: every held entry in order, plus whether the head is visible
   logic [15:0] exp_q[$];
   logic        m_vis;
   logic [15:0] m_data;
   logic        m_dknown;
   logic        m_ovf, m_udf;

   typedef struct {
      logic        rst, fl, wr;
      logic [15:0] wd;
      logic        rd, clr;
      logic [3:0]  e_level;
      logic        e_valid;
      logic [15:0] e_data;
      logic        e_empty, e_full, e_afull, e_aempty, e_ovf, e_udf;
   } vec_t;
   vec_t tv[$];

   rpc2_ctrl_sync_fifo #(.FIFO_ADDR_BITS(3), .FIFO_DATA_WIDTH(16), .SPLIT_MEM(0),
                         .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)) dut_a (
      .clk(clk), .reset(reset), .i_flush(i_flush), .i_wr_en(i_wr_en),
      .i_wr_data(i_wr_data), .o_full(full[0]), .o_afull(afull[0]),
      .i_rd_en(i_rd_en), .o_rd_valid(rd_valid[0]), .o_rd_data(rd_data[0]),
      .o_empty(empty[0]), .o_aempty(aempty[0]), .o_level(level[0]),
      .o_ovf(ovf[0]), .o_udf(udf[0]), .i_err_clr(i_err_clr));

   rpc2_ctrl_sync_fifo #(.FIFO_ADDR_BITS(3), .FIFO_DATA_WIDTH(16), .SPLIT_MEM(1),
                         .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)) dut_b (
      .clk(clk), .reset(reset), .i_flush(i_flush), .i_wr_en(i_wr_en),
      .i_wr_data(i_wr_data), .o_full(full[1]), .o_afull(afull[1]),
      .i_rd_en(i_rd_en), .o_rd_valid(rd_valid[1]), .o_rd_data(rd_data[1]),
      .o_empty(empty[1]), .o_aempty(aempty[1]), .o_level(level[1]),
      .o_ovf(ovf[1]), .o_udf(udf[1]), .i_err_clr(i_err_clr));

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
      end
   endtask

   // model advance for one clock edge with the given inputs
   task automatic model_step(input logic rst, fl, wr, input logic [15:0] wd, input logic rd, clr);
      int   held, in_ram;
      logic pop, push, fire, ovf_set, udf_set;
      if (rst) begin
         exp_q.delete();
         m_vis = 0; m_data = '0; m_dknown = 1; m_ovf = 0; m_udf = 0;
      end else if (fl) begin
         exp_q.delete();
         m_vis = 0; m_dknown = 0;
      end else begin
         held    = exp_q.size();
         ovf_set = wr && (held == DEPTH);
         udf_set = rd && !m_vis;
         pop     = rd && m_vis;
         push    = wr && (held < DEPTH);
         in_ram  = held - (m_vis ? 1 : 0);
         fire    = (!m_vis || pop) && (in_ram > 0);
         if (pop) void'(exp_q.pop_front());
         if (push) exp_q.push_back(wd);
         if (fire) begin
            m_vis = 1; m_data = exp_q[0]; m_dknown = 1;
         end else if (pop) begin
            m_vis = 0;
         end
         m_ovf = ovf_set || (m_ovf && !clr);
         m_udf = udf_set || (m_udf && !clr);
      end
   endtask

   task automatic check_model();
      int n;
      n = exp_q.size();
      for (int d = 0; d < 2; d++) begin
         chk("m_level",  d, 32'(level[d]),  32'(n));
         chk("m_empty",  d, 32'(empty[d]),  32'(n == 0));
         chk("m_full",   d, 32'(full[d]),   32'(n == DEPTH));
         chk("m_afull",  d, 32'(afull[d]),  32'(n >= AFULL));
         chk("m_aempty", d, 32'(aempty[d]), 32'(n <= AEMPTY));
         chk("m_valid",  d, 32'(rd_valid[d]), 32'(m_vis));
         chk("m_ovf",    d, 32'(ovf[d]),    32'(m_ovf));
         chk("m_udf",    d, 32'(udf[d]),    32'(m_udf));
         if (m_dknown) chk("m_data", d, 32'(rd_data[d]), 32'(m_data));
      end
   endtask

   // driver: apply inputs for one cycle, then sample #1 after the edge
   task automatic step(input logic rst, fl, wr, input logic [15:0] wd, input logic rd, clr);
      reset = rst; i_flush = fl; i_wr_en = wr; i_wr_data = wd; i_rd_en = rd; i_err_clr = clr;
      model_step(rst, fl, wr, wd, rd, clr);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic add_vec(input logic rst, fl, wr, input logic [15:0] wd, input logic rd, clr,
                          input int lvl, input logic v, input logic [15:0] dat, input logic eo, eu);
      vec_t r;
      r.rst = rst; r.fl = fl; r.wr = wr; r.wd = wd; r.rd = rd; r.clr = clr;
      r.e_level = 4'(lvl); r.e_valid = v; r.e_data = dat;
      r.e_empty = (lvl == 0); r.e_full = (lvl == 8); r.e_afull = (lvl >= 6); r.e_aempty = (lvl <= 2);
      r.e_ovf = eo; r.e_udf = eu;
      tv.push_back(r);
   endtask

   initial begin
      reset = 1; i_flush = 0; i_wr_en = 0; i_wr_data = '0; i_rd_en = 0; i_err_clr = 0;
      exp_q.delete(); m_vis = 0; m_data = '0; m_dknown = 0; m_ovf = 0; m_udf = 0;

      // directed vectors: reset, single push latency, fill/overflow/drain, underflow clear
      add_vec(1,0,0,16'h0,0,0, 0,0,16'h0,0,0);
      add_vec(0,0,0,16'h0,0,0, 0,0,16'h0,0,0);
      add_vec(0,0,1,16'h1111,0,0, 1,0,16'h0,0,0);
      add_vec(0,0,0,16'h0,0,0, 1,1,16'h1111,0,0);
      add_vec(0,0,0,16'h0,1,0, 0,0,16'h1111,0,0);
      for (int i = 1; i <= 8; i++)
         add_vec(0,0,1,16'(i),0,0, i, (i >= 2), (i == 1) ? 16'h1111 : 16'h0001, 0,0);
      add_vec(0,0,1,16'h0009,0,0, 8,1,16'h0001,1,0);
      for (int k = 1; k <= 8; k++)
         add_vec(0,0,0,16'h0,1,0, 8-k, (k < 8), (k < 8) ? 16'(k+1) : 16'h0008, 1,0);
      add_vec(0,0,0,16'h0,0,1, 0,0,16'h0008,0,0);
      add_vec(0,0,0,16'h0,1,0, 0,0,16'h0008,0,1);
      add_vec(0,0,0,16'h0,1,1, 0,0,16'h0008,0,1);
      add_vec(0,0,0,16'h0,0,1, 0,0,16'h0008,0,0);

      @(negedge clk);
      foreach (tv[i]) begin
         step(tv[i].rst, tv[i].fl, tv[i].wr, tv[i].wd, tv[i].rd, tv[i].clr);
         for (int d = 0; d < 2; d++) begin
            chk("v_level",  d, 32'(level[d]),    32'(tv[i].e_level));
            chk("v_valid",  d, 32'(rd_valid[d]), 32'(tv[i].e_valid));
            chk("v_data",   d, 32'(rd_data[d]),  32'(tv[i].e_data));
            chk("v_empty",  d, 32'(empty[d]),    32'(tv[i].e_empty));
            chk("v_full",   d, 32'(full[d]),     32'(tv[i].e_full));
            chk("v_afull",  d, 32'(afull[d]),    32'(tv[i].e_afull));
            chk("v_aempty", d, 32'(aempty[d]),   32'(tv[i].e_aempty));
            chk("v_ovf",    d, 32'(ovf[d]),      32'(tv[i].e_ovf));
            chk("v_udf",    d, 32'(udf[d]),      32'(tv[i].e_udf));
         end
      end

      // steady state at level 4 with simultaneous push/pop across pointer wrap
      for (int i = 0; i < 4; i++) step(0,0,1,16'(16'h0100 + i),0,0);
      step(0,0,0,16'h0,0,0);
      for (int i = 0; i < 20; i++) begin
         step(0,0,1,16'(16'h0200 + i),1,0);
         for (int d = 0; d < 2; d++) begin
            chk("wrap_level",  d, 32'(level[d]),    32'd4);
            chk("wrap_valid",  d, 32'(rd_valid[d]), 32'd1);
            chk("wrap_aempty", d, 32'(aempty[d]),   32'd0);
            chk("wrap_afull",  d, 32'(afull[d]),    32'd0);
         end
      end

      // flush mid-operation with a push in the same cycle; ovf must survive
      step(0,1,0,16'h0,0,0);
      for (int i = 0; i < 9; i++) step(0,0,1,16'(16'h0300 + i),0,0);
      for (int i = 0; i < 3; i++) step(0,0,0,16'h0,1,0);
      for (int d = 0; d < 2; d++) chk("pre_flush_level", d, 32'(level[d]), 32'd5);
      step(0,1,1,16'hdead,1,0);
      for (int d = 0; d < 2; d++) begin
         chk("flush_level", d, 32'(level[d]),    32'd0);
         chk("flush_valid", d, 32'(rd_valid[d]), 32'd0);
         chk("flush_empty", d, 32'(empty[d]),    32'd1);
         chk("flush_ovf",   d, 32'(ovf[d]),      32'd1);
         chk("flush_udf",   d, 32'(udf[d]),      32'd0);
      end

      // same situation but with reset: everything returns to reset values
      for (int i = 0; i < 5; i++) step(0,0,1,16'(16'h0400 + i),0,0);
      step(1,0,1,16'hbeef,0,0);
      for (int d = 0; d < 2; d++) begin
         chk("rst_level",  d, 32'(level[d]),    32'd0);
         chk("rst_valid",  d, 32'(rd_valid[d]), 32'd0);
         chk("rst_data",   d, 32'(rd_data[d]),  32'd0);
         chk("rst_empty",  d, 32'(empty[d]),    32'd1);
         chk("rst_aempty", d, 32'(aempty[d]),   32'd1);
         chk("rst_full",   d, 32'(full[d]),     32'd0);
         chk("rst_afull",  d, 32'(afull[d]),    32'd0);
         chk("rst_ovf",    d, 32'(ovf[d]),      32'd0);
         chk("rst_udf",    d, 32'(udf[d]),      32'd0);
      end

      // randomized traffic, alternating fill-biased and drain-biased phases
      for (int c = 0; c < 4000; c++) begin
         int   wr_pct, rd_pct;
         logic r_rst, r_fl, r_wr, r_rd, r_clr;
         wr_pct = ((c / 250) % 2 == 0) ? 75 : 30;
         rd_pct = ((c / 250) % 2 == 0) ? 30 : 75;
         r_rst  = ($urandom_range(0, 699) == 0);
         r_fl   = ($urandom_range(0, 199) == 0);
         r_wr   = ($urandom_range(0, 99) < wr_pct);
         r_rd   = ($urandom_range(0, 99) < rd_pct);
         r_clr  = ($urandom_range(0, 39) == 0);
         step(r_rst, r_fl, r_wr, 16'($urandom), r_rd, r_clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rpc2_ctrl_sync_fifo.md
Name: rpc2_ctrl_sync_fifo

Overview:
- Single-clock, parametrised first-word-fall-through (FWFT) FIFO.
- Successor to the controller's bare DPRAM generator: keeps the same storage organisation choices, plus pointer/level management, full/empty and programmable almost flags, flush, and sticky error flags.
- Used for same-clock buffering inside the controller: AXI ID queues, response data, address staging.

Parameters:
- FIFO_ADDR_BITS, 3: depth = 1<<FIFO_ADDR_BITS entries; legal 2..8.
- FIFO_DATA_WIDTH, 16: entry width in bits; must be even when SPLIT_MEM=1.
- SPLIT_MEM, 0: 0 = one memory array; 1 = two half-width arrays written/read together. No functional difference.
- AFULL_LEVEL, 6: o_afull asserted when level >= AFULL_LEVEL; legal 1..depth.
- AEMPTY_LEVEL, 2: o_aempty asserted when level <= AEMPTY_LEVEL; legal 0..depth-1.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous clear of contents; error flags are kept.
- i_wr_en  input  1  push request.
- i_wr_data  input  FIFO_DATA_WIDTH  push data.
- o_full  output  1  level == depth.
- o_afull  output  1  level >= AFULL_LEVEL.
- i_rd_en  input  1  pop request; consumes o_rd_data when o_rd_valid=1.
- o_rd_valid  output  1  o_rd_data holds the head entry.
- o_rd_data  output  FIFO_DATA_WIDTH  head entry (FWFT).
- o_empty  output  1  level == 0.
- o_aempty  output  1  level <= AEMPTY_LEVEL.
- o_level  output  FIFO_ADDR_BITS+1  entries held, including the output stage.
- o_ovf  output  1  sticky: push attempted while full.
- o_udf  output  1  sticky: pop attempted while o_rd_valid=0.
- i_err_clr  input  1  clears o_ovf and o_udf.

Behaviour:
- Reset: all pointers = 0. Outputs: o_level=0, o_empty=1, o_aempty=1, o_full=0, o_afull=(AFULL_LEVEL==0, i.e. 0 for legal values), o_rd_valid=0, o_rd_data=0, o_ovf=0, o_udf=0. Memory contents are not reset. Reset overrides every other input.
- Storage: memory with write pointer wp and read pointer rp, each FIFO_ADDR_BITS+1 bits (an extra wrap bit).
  - RAM empty when wp==rp.
  - Memory write on accepted push: mem[wp] <= i_wr_data, then wp++.
- Output stage: the registered memory read data is o_rd_data.
  - Internal read fires when (!o_rd_valid || pop_acc) && RAM not empty.
  - On read: o_rd_data <= mem[rp], rp++, o_rd_valid <= 1.
  - If pop_acc occurs and no read fires: o_rd_valid <= 0; o_rd_data holds its last value.
- Handshakes:
  - push_acc = i_wr_en && !o_full.
  - pop_acc = i_rd_en && o_rd_valid.
  - Both may happen in the same cycle, including when full (push refused) and when level==1 (the pop frees the output stage).
- Latency:
  - Push in cycle c into an empty FIFO gives o_rd_valid=1 in cycle c+2.
  - Back-to-back pops sustain one entry per cycle while entries remain.
  - A write and a read never target the same address in the same cycle, because a read fires only when the RAM is non-empty at the start of the cycle.
- Level: o_level next = o_level + push_acc - pop_acc. o_level is registered. All four flags are registered and derived from the next level, so they are cycle-exact with o_level.
- Full: o_full=1 exactly when o_level == 1<<FIFO_ADDR_BITS. The total held, RAM plus output stage, never exceeds depth.
- Errors:
  - o_ovf set on i_wr_en && o_full; o_udf set on i_rd_en && !o_rd_valid.
  - On i_err_clr: clear, except a same-cycle new error sets the flag (set wins).
- Flush: next cycle wp=rp=0, o_level=0, o_rd_valid=0, flags return to reset values. A push or pop in the flush cycle is ignored and raises no error flag; o_ovf/o_udf are unchanged.
- Wrap-around: pointers wrap modulo 2^(FIFO_ADDR_BITS+1). Data order is preserved across any number of wraps.

Test Plan:
- Defaults (depth 8): reset then idle -> o_empty=1, o_aempty=1, o_level=0, o_rd_valid=0, o_rd_data=0, flags 0.
- Push 0x1111 in cycle 0 only -> cycle 2: o_rd_valid=1, o_rd_data=0x1111, o_level=1. Pop in cycle 2 -> cycle 3: o_rd_valid=0, o_empty=1.
- Push 0x0001..0x0008 on consecutive cycles, no pops:
  - o_afull rises together with o_level=6; o_full=1 with o_level=8.
  - A 9th push sets o_ovf=1 and leaves o_level=8.
  - Draining with continuous pops returns 0x0001..0x0008 in order, one per cycle.
- Fill to 4, then push and pop together for 20 cycles with incrementing data -> o_level stays 4, no gaps in o_rd_valid, order preserved across pointer wrap; o_aempty=0, o_afull=0 throughout.
- Pop while empty -> o_udf=1. Assert i_err_clr together with another empty pop -> o_udf stays 1. Next cycle, i_err_clr alone -> o_udf=0.
- Mid-operation events:
  - Fill to 5, assert i_flush with i_wr_en=1 -> next cycle o_level=0, o_rd_valid=0, o_empty=1, o_ovf unchanged.
  - Repeat with reset=1 instead of i_flush -> all outputs at reset values, including o_ovf=0.
  - Run both for SPLIT_MEM=0 and 1; results identical.
